// File: rtl/gf2m_arith_if.sv
// Start/done handshake and operand/result bus for the GF(2^M) arithmetic unit.
interface gf2m_arith_if #(
  parameter int M  = 163,
  parameter int KW = 8
);
  logic          start;
  logic [1:0]    mode;
  logic [KW-1:0] sqr_k;
  logic [M-1:0]  A;
  logic [M-1:0]  B;
  logic [M-1:0]  C;
  logic          busy;
  logic          done;

  modport master (output start, mode, sqr_k, A, B, input C, busy, done);
  modport slave  (input start, mode, sqr_k, A, B, output C, busy, done);
endinterface

// File: rtl/gf2m_arith_unit.sv
// Sequential GF(2^M) engine: bit-serial MSB-first multiply, k-fold squaring,
// fused multiply-then-square and field add behind one start/done handshake.
module gf2m_arith_unit #(
  parameter int           M    = 163,
  parameter logic [M-1:0] POLY = 'hC9,
  parameter int           KW   = 8
) (
  input  logic      clk,
  input  logic      rst,
  gf2m_arith_if.slave bus
);
  localparam int IW = $clog2(M);
  localparam logic [1:0] OP_MUL = 2'b00, OP_SQR = 2'b01, OP_MULSQR = 2'b10, OP_ADD = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_SQR, ST_DONE} state_t;

  state_t        state, state_nxt;
  logic [M-1:0]  z, z_nxt, a_r, a_nxt, b_r, b_nxt, c_r, c_nxt;
  logic [1:0]    mode_r, mode_nxt;
  logic [KW-1:0] k_cnt, k_nxt;
  logic [IW-1:0] i_cnt, i_nxt;
  logic          busy_r, busy_nxt, done_r, done_nxt;
  logic [M-1:0]  z_mul, z_sqr;

  // Spread to 2M-1 bits, then fold the high terms back down from the top.
  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] v);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) t[2*i] = v[i];
    for (int j = 2*M-2; j >= M; j--) begin
      if (t[j]) begin
        t[j-M +: M] = t[j-M +: M] ^ POLY;
        t[j]        = 1'b0;
      end
    end
    return t[M-1:0];
  endfunction

  assign z_mul = {z[M-2:0], 1'b0} ^ (z[M-1] ? POLY : '0) ^ (b_r[i_cnt] ? a_r : '0);
  assign z_sqr = gf_sqr(z);

  always_comb begin
    state_nxt = state;
    z_nxt     = z;
    a_nxt     = a_r;
    b_nxt     = b_r;
    c_nxt     = c_r;
    mode_nxt  = mode_r;
    k_nxt     = k_cnt;
    i_nxt     = i_cnt;
    busy_nxt  = busy_r;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          a_nxt    = bus.A;
          b_nxt    = bus.B;
          mode_nxt = bus.mode;
          k_nxt    = bus.sqr_k;
          busy_nxt = 1'b1;
          case (bus.mode)
            OP_MUL, OP_MULSQR: begin
              z_nxt     = '0;
              i_nxt     = IW'(M-1);
              state_nxt = ST_MUL;
            end
            OP_SQR: begin
              z_nxt     = bus.A;
              state_nxt = (bus.sqr_k != '0) ? ST_SQR : ST_DONE;
            end
            default: begin
              z_nxt     = bus.A ^ bus.B;
              state_nxt = ST_DONE;
            end
          endcase
        end
      end
      ST_MUL: begin
        z_nxt = z_mul;
        if (i_cnt == '0)
          state_nxt = (mode_r == OP_MULSQR && k_cnt != '0) ? ST_SQR : ST_DONE;
        else
          i_nxt = i_cnt - IW'(1);
      end
      ST_SQR: begin
        z_nxt = z_sqr;
        k_nxt = k_cnt - KW'(1);
        if (k_cnt == KW'(1)) state_nxt = ST_DONE;
      end
      default: begin
        // Result lands in C together with the done pulse; unit is free again.
        c_nxt     = z;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      z      <= '0;
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= '0;
      mode_r <= '0;
      k_cnt  <= '0;
      i_cnt  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      z      <= z_nxt;
      a_r    <= a_nxt;
      b_r    <= b_nxt;
      c_r    <= c_nxt;
      mode_r <= mode_nxt;
      k_cnt  <= k_nxt;
      i_cnt  <= i_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
    end
  end

  assign bus.C    = c_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule
